adder_tree_ich_acc: RTL

Parametrised input-channel reduction tree with tile accumulation and valid/ready flow control. Each accepted beat carries NUM_CH signed partial sums. The block reduces them through a configurable-depth pipelined adder tree. It then accumulates successive beats, framed by first/last flags, into one OUT_WIDTH result, so that layers with more than NUM_CH input channels reduce in multiple passes. It sits between the PE array output and the output-channel post-processing stage.

---
 rtl/adder_tree_ich_acc.sv | 130 +++++++++++++
 1 files changed

// File: rtl/adder_tree_ich_acc.sv
// Input-channel reduction: pipelined adder tree over NUM_CH signed partial sums,
// followed by a first/last framed group accumulator with optional saturation.
module adder_tree_ich_acc #(
   parameter int unsigned NUM_CH    = 32,
   parameter int unsigned IN_WIDTH  = 16,
   parameter int unsigned OUT_WIDTH = 32,
   parameter int unsigned REG_EVERY = 2,
   parameter bit          SAT_EN    = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_first,
   input  logic                         in_last,
   input  logic [NUM_CH*IN_WIDTH-1:0]   in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OUT_WIDTH-1:0]         out_data,
   output logic                         out_ovf
);

   localparam int unsigned LEVELS = $clog2(NUM_CH);
   localparam int unsigned TW     = IN_WIDTH + LEVELS;
   localparam int unsigned T      = (LEVELS + REG_EVERY - 1) / REG_EVERY;
   localparam int unsigned NODES  = 2 * NUM_CH - 1;
   localparam int unsigned AW     = OUT_WIDTH + 1;

   localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   // Tree is a binary heap: node n sums nodes 2n+1 and 2n+2; leaves are channels.
   function automatic int unsigned node_level(input int unsigned n);
      return LEVELS + 1 - $clog2(n + 2);
   endfunction

   logic                    w_adv;
   logic signed [TW-1:0]    w_node [NODES];

   logic [T-1:0]            r_pv;
   logic [T-1:0]            r_pf;
   logic [T-1:0]            r_pl;

   logic [OUT_WIDTH-1:0]    r_acc;
   logic                    r_ovf;
   logic                    r_open;
   logic                    r_out_valid;
   logic [OUT_WIDTH-1:0]    r_out_data;
   logic                    r_out_ovf;

   logic                    w_restart;
   logic [AW-1:0]           w_base;
   logic [AW-1:0]           w_sum;
   logic                    w_fit;
   logic [OUT_WIDTH-1:0]    w_acc_nxt;
   logic                    w_ovf_nxt;

   assign w_adv    = !r_out_valid || out_ready;
   assign in_ready = w_adv;

   for (genvar n = 0; n < NODES; n++) begin : g_node
      if (n >= NUM_CH - 1) begin : g_leaf
         localparam int unsigned C = n - (NUM_CH - 1);
         assign w_node[n] = {{LEVELS{in_data[C*IN_WIDTH + IN_WIDTH - 1]}},
                             in_data[C*IN_WIDTH +: IN_WIDTH]};
      end else if ((node_level(n) % REG_EVERY) == 0 || n == 0) begin : g_reg
         logic signed [TW-1:0] r_sum;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)        r_sum <= '0;
            else if (w_adv) r_sum <= w_node[2*n+1] + w_node[2*n+2];
         end
         assign w_node[n] = r_sum;
      end else begin : g_comb
         assign w_node[n] = w_node[2*n+1] + w_node[2*n+2];
      end
   end

   // Beat flags travel alongside the tree registers, one bit per stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pv <= '0;
         r_pf <= '0;
         r_pl <= '0;
      end else if (w_adv) begin
         r_pv <= T'({r_pv, in_valid});
         r_pf <= T'({r_pf, in_first});
         r_pl <= T'({r_pl, in_last});
      end
   end

   always_comb begin
      w_restart = r_pf[T-1] || !r_open;
      w_base    = w_restart ? '0 : AW'($signed(r_acc));
      w_sum     = AW'(w_node[0]) + w_base;
      w_fit     = (w_sum[AW-1] == w_sum[AW-2]);
      w_acc_nxt = w_sum[OUT_WIDTH-1:0];
      if (!w_fit && SAT_EN) w_acc_nxt = w_sum[AW-1] ? SAT_MIN : SAT_MAX;
      w_ovf_nxt = (!w_restart && r_ovf) || !w_fit;
   end

   // A closing beat loads the result; any other beat opens or continues the group.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc       <= '0;
         r_ovf       <= 1'b0;
         r_open      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ovf   <= 1'b0;
      end else if (w_adv) begin
         r_out_valid <= r_pv[T-1] && r_pl[T-1];
         if (r_pv[T-1]) begin
            if (r_pl[T-1]) begin
               r_out_data <= w_acc_nxt;
               r_out_ovf  <= w_ovf_nxt;
               r_open     <= 1'b0;
            end else begin
               r_acc  <= w_acc_nxt;
               r_ovf  <= w_ovf_nxt;
               r_open <= 1'b1;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_ovf   = r_out_ovf;

endmodule
